ws_scale_addr_gen: RTL and testbench
====================================

Name: ws_scale_addr_gen

Overview:
- Sits between the HDMI timing core and the WonderSwan framebuffer RAM.
- Takes the output pixel coordinate stream (cx, cy) and produces framebuffer read addresses for 224x144 WS pixels.
- Applies integer scaling, centring and optional 90° portrait rotation.
- Uses only counters and adders: no multipliers, no dividers.

Parameters:
FRAMEWIDTH, 720, visible output width in pixels
FRAMEHEIGHT, 480, visible output height in lines
SCALE, 3, integer scale factor, landscape
SCALEROT, 2, integer scale factor, portrait
WS_W, 224, WS source width
WS_H, 144, WS source height
CXW, 11, cx width
CYW, 10, cy width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
cx  in  CXW  output pixel x; increments by 1 per clk, wraps to 0 at line end
cy  in  CYW  output line y; changes when cx wraps to 0
rotate  in  1  portrait mode request; sampled only at frame start
rd_addr  out  15  framebuffer read address, sy*WS_W+sx
rd_en  out  1  read strobe; high while the pixel is inside the image window
active  out  1  same as rd_en; kept for the border/colour mux
scanline  out  1  last sub-row of a source row (see Optional Feature)

Behaviour:
- Reset (async, rst=1): rd_addr=0, rd_en=0, active=0, scanline=0, all counters 0, rot_q=0.
- Frame start is cx==0 && cy==0. At frame start rot_q<=rotate. A rotate change mid-frame has no effect until the next frame start.
- Effective values, landscape (rot_q=0):
  - S=SCALE; IW=WS_W*S; IH=WS_H*S.
  - START=0; HSTEP=+1; VSTEP=+WS_W.
- Effective values, portrait (rot_q=1):
  - S=SCALEROT; IW=WS_H*S; IH=WS_W*S.
  - START=(WS_H-1)*WS_W=32032; HSTEP=-WS_W; VSTEP=+1.
- Offsets: HOFF=(FRAMEWIDTH-IW)/2, VOFF=(FRAMEHEIGHT-IH)/2. With defaults: landscape HOFF=24, VOFF=24; portrait HOFF=216, VOFF=16. All are constants per mode.
- Vertical tracking, evaluated when cx==0:
  - cy==VOFF: rowbase<=START, vsub<=0, vin<=1.
  - cy==VOFF+IH: vin<=0.
  - Otherwise, if vin: vsub increments; when it reaches S-1 it wraps to 0 and rowbase<=rowbase+VSTEP.
- Horizontal state machine, reset each line when cx==0:
  - H_PRE: enter H_ACT when cx==HOFF && vin; set addr<=rowbase, hsub<=0.
  - H_ACT: each clk hsub increments; when hsub==S-1, hsub<=0 and addr<=addr+HSTEP (15-bit modular add). Go to H_POST when cx==HOFF+IW-1.
  - H_POST: hold until cx==0, then return to H_PRE.
- Outputs are registered; latency is exactly 1 clk.
  - rd_addr, rd_en, active correspond to the cx/cy presented on the previous cycle.
  - Downstream aligns colour for the RAM's own 1-clk read latency.
- Outside the window: rd_en=active=0 and rd_addr holds its last value.
- Address range: never exceeds 32255.
  - Landscape last pixel = 143*224+223.
  - Portrait last pixel = 0*224+223 = 223; its first pixel = 32032.
- cx/cy jumping non-monotonically (e.g. a timing-core reset): the state machine resyncs at the next cx==0. Outputs for that line are undefined but rd_addr stays within 0..32767.

Optional Feature:
Macro SCANLINE_EN.
- Defined: scanline=1, registered and aligned with active, when active && vsub==S-1 (last replicated line of each source row). The colour stage darkens those pixels.
- Undefined: scanline is tied to 0 and the logic is removed.

Test Plan:
1. Reset asserted mid-line at cx=100, cy=50 -> next clk rd_en=0, rd_addr=0, scanline=0; after release, correct output resumes from the next frame start.
2. Landscape, cy=24 -> first rd_en=1 one clk after cx=24 with rd_addr=0; addr 1 appears after cx=27; rd_en falls one clk after cx=696; row 1 (rd_addr=224 at cx=24) starts at cy=27.
3. Landscape, last line cy=455 -> final rd_addr=32255; cy=456 gives rd_en=0 for the whole line.
4. rotate=1 latched at frame start -> cy=16 at cx=216 gives rd_addr=32032, then 31808 after 2 clks; cy=18 starts at 32033; last pixel at cy=463, cx=503 gives 223.
5. rotate toggled at cy=200 -> no change in address sequence until the next frame start; the next frame uses the new mode.
6. SCANLINE_EN defined, landscape -> scanline=1 on cy=26, 29, …, 455 inside the window and 0 elsewhere; with the macro undefined, always 0.

Source files
------------

// File: rtl/ws_scale_addr_gen.sv
// ws_scale_addr_gen: maps HDMI pixel coordinates to WonderSwan framebuffer read addresses with integer scaling, centring and optional portrait rotation.
// Build with SCANLINE_EN defined to flag the last replicated line of each source row on scanline.
module ws_scale_addr_gen #(
    parameter int FRAMEWIDTH  = 720,
    parameter int FRAMEHEIGHT = 480,
    parameter int SCALE       = 3,
    parameter int SCALEROT    = 2,
    parameter int WS_W        = 224,
    parameter int WS_H        = 144,
    parameter int CXW         = 11,
    parameter int CYW         = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CXW-1:0] cx,
    input  logic [CYW-1:0] cy,
    input  logic           rotate,
    output logic [14:0]    rd_addr,
    output logic           rd_en,
    output logic           active,
    output logic           scanline
);
    localparam int SMAX = SCALE > SCALEROT ? SCALE : SCALEROT;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int IW_L = WS_W * SCALE;
    localparam int IH_L = WS_H * SCALE;
    localparam int IW_P = WS_H * SCALEROT;
    localparam int IH_P = WS_W * SCALEROT;
    localparam logic [CXW-1:0] HOFF_L = CXW'((FRAMEWIDTH - IW_L) / 2);
    localparam logic [CXW-1:0] HOFF_P = CXW'((FRAMEWIDTH - IW_P) / 2);
    localparam logic [CXW-1:0] HEND_L = CXW'((FRAMEWIDTH - IW_L) / 2 + IW_L - 1);
    localparam logic [CXW-1:0] HEND_P = CXW'((FRAMEWIDTH - IW_P) / 2 + IW_P - 1);
    localparam logic [CYW-1:0] VOFF_L = CYW'((FRAMEHEIGHT - IH_L) / 2);
    localparam logic [CYW-1:0] VOFF_P = CYW'((FRAMEHEIGHT - IH_P) / 2);
    localparam logic [CYW-1:0] VEND_L = CYW'((FRAMEHEIGHT - IH_L) / 2 + IH_L);
    localparam logic [CYW-1:0] VEND_P = CYW'((FRAMEHEIGHT - IH_P) / 2 + IH_P);
    localparam logic [14:0] START_P = 15'((WS_H - 1) * WS_W);
    // Portrait walks up the source columns, so the horizontal step is -WS_W modulo 2^15.
    localparam logic [14:0] HSTEP_P = 15'(32768 - WS_W);
    localparam logic [14:0] VSTEP_L = 15'(WS_W);

    typedef enum logic [1:0] {H_PRE, H_ACT, H_POST} hstate_t;

    hstate_t        hs;
    logic           rot_q, vin;
    logic [SW-1:0]  vsub, hsub, s_m1;
    logic [14:0]    rowbase, start, hstep, vstep;
    logic [CXW-1:0] hoff, hend;
    logic [CYW-1:0] voff, vend;
    logic           start_h, en_n, last_v, last_h;

    always_comb begin
        hoff    = rot_q ? HOFF_P : HOFF_L;
        hend    = rot_q ? HEND_P : HEND_L;
        voff    = rot_q ? VOFF_P : VOFF_L;
        vend    = rot_q ? VEND_P : VEND_L;
        start   = rot_q ? START_P : 15'd0;
        hstep   = rot_q ? HSTEP_P : 15'd1;
        vstep   = rot_q ? 15'd1 : VSTEP_L;
        s_m1    = rot_q ? SW'(SCALEROT - 1) : SW'(SCALE - 1);
        last_v  = vsub == s_m1;
        last_h  = hsub == s_m1;
        start_h = hs == H_PRE && cx == hoff && vin;
        en_n    = start_h || hs == H_ACT;
    end

    assign active = rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs      <= H_PRE;
            rot_q   <= 1'b0;
            vin     <= 1'b0;
            vsub    <= '0;
            hsub    <= '0;
            rowbase <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
        end else begin
            if (cx == '0 && cy == '0)
                rot_q <= rotate;
            if (cx == '0) begin
                if (cy == voff) begin
                    rowbase <= start;
                    vsub    <= '0;
                    vin     <= 1'b1;
                end else if (cy == vend) begin
                    vin <= 1'b0;
                end else if (vin) begin
                    vsub <= last_v ? '0 : vsub + SW'(1);
                    if (last_v)
                        rowbase <= rowbase + vstep;
                end
            end
            rd_en <= en_n;
            case (hs)
                H_PRE: if (start_h) begin
                    hs      <= H_ACT;
                    rd_addr <= rowbase;
                    hsub    <= '0;
                end
                H_ACT: begin
                    hsub <= last_h ? '0 : hsub + SW'(1);
                    if (last_h)
                        rd_addr <= rd_addr + hstep;
                    if (cx == hend)
                        hs <= H_POST;
                end
                default: ;
            endcase
            // Any line start forces a resync, which also recovers from cx/cy jumps.
            if (cx == '0)
                hs <= H_PRE;
        end
    end

`ifdef SCANLINE_EN
    logic sc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sc <= 1'b0;
        else
            sc <= en_n && last_v;
    end
    assign scanline = sc;
`else
    assign scanline = 1'b0;
`endif
endmodule

// File: tb/tb_ws_scale_addr_gen.sv
// tb_ws_scale_addr_gen: geometric reference model plus literal spot checks for ws_scale_addr_gen.
module tb_ws_scale_addr_gen;
    logic        clk = 1'b0, rst = 1'b1, rotate = 1'b0;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic [14:0] rd_addr;
    logic        rd_en, active, scanline;

    ws_scale_addr_gen dut (
        .clk(clk), .rst(rst), .cx(cx), .cy(cy), .rotate(rotate),
        .rd_addr(rd_addr), .rd_en(rd_en), .active(active), .scanline(scanline)
    );

    always #5 clk = ~clk;

    // Returns {in_window, scanline, address} from the picture geometry directly.
    function automatic logic [16:0] model(input int x, input int y, input logic r);
        int s, iw, ih, lx, ly, sx, sy, a;
        logic in_w, sc;
        s    = r ? 2 : 3;
        iw   = r ? 144 * s : 224 * s;
        ih   = r ? 224 * s : 144 * s;
        lx   = x - (720 - iw) / 2;
        ly   = y - (480 - ih) / 2;
        in_w = lx >= 0 && lx < iw && ly >= 0 && ly < ih;
        sx   = in_w ? lx / s : 0;
        sy   = in_w ? ly / s : 0;
        a    = r ? (143 - sx) * 224 + sy : sy * 224 + sx;
        sc   = 1'b0;
`ifdef SCANLINE_EN
        sc   = in_w && (ly % s) == s - 1;
`endif
        return {in_w, sc, 15'(a)};
    endfunction

    logic        rot_m = 1'b0, synced = 1'b0, exp_en = 1'b0, exp_sc = 1'b0, prot = 1'b0;
    logic [14:0] exp_addr = '0;
    int          px = 0, py = 0;
    logic        rf;
    logic [16:0] m;
    assign rf = (cx == 0 && cy == 0) ? rotate : rot_m;
    assign m  = model(int'(cx), int'(cy), rf);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_m    <= 1'b0;
            synced   <= 1'b0;
            exp_en   <= 1'b0;
            exp_sc   <= 1'b0;
            exp_addr <= '0;
        end else begin
            if (cx == 0 && cy == 0) begin
                rot_m  <= rotate;
                synced <= 1'b1;
            end
            exp_en <= m[16] && synced;
            exp_sc <= m[16] && synced && m[15];
            if (m[16] && synced)
                exp_addr <= m[14:0];
        end
    end

    always @(posedge clk) begin
        px   <= int'(cx);
        py   <= int'(cy);
        prot <= rf;
    end

    int   total = 0, bad = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (prev cx=%0d cy=%0d)", n, got, want, px, py);
        end
    endtask

    task automatic lit();
        if (!prot) begin
            if (py == 24 && px == 24) begin
                chk("l_first_en", rd_en, 1);
                chk("l_first_addr", rd_addr, 0);
            end
            if (py == 24 && px == 26) chk("l_hold_addr", rd_addr, 0);
            if (py == 24 && px == 27) chk("l_step_addr", rd_addr, 1);
            if (py == 24 && px == 695) chk("l_end_addr", rd_addr, 223);
            if (py == 24 && px == 696) chk("l_end_en", rd_en, 0);
            if (py == 27 && px == 24) chk("l_row1_addr", rd_addr, 224);
            if (py == 455 && px == 695) chk("l_last_addr", rd_addr, 32255);
            if (py == 456 && px == 360) chk("l_below_en", rd_en, 0);
`ifdef SCANLINE_EN
            if (py == 26 && px == 100) chk("l_scan_on", scanline, 1);
            if (py == 25 && px == 100) chk("l_scan_off", scanline, 0);
`endif
        end else begin
            if (py == 16 && px == 216) chk("p_first_addr", rd_addr, 32032);
            if (py == 16 && px == 218) chk("p_step_addr", rd_addr, 31808);
            if (py == 18 && px == 216) chk("p_row1_addr", rd_addr, 32033);
            if (py == 200 && px == 300) chk("p_mid_addr", rd_addr, 22716);
            if (py == 463 && px == 503) chk("p_last_addr", rd_addr, 223);
            if (py == 463 && px == 504) chk("p_end_en", rd_en, 0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rd_en", rd_en, exp_en);
            chk("active", active, exp_en);
            chk("rd_addr", rd_addr, exp_addr);
            chk("scanline", scanline, exp_sc);
            if (rst) begin
                chk("rst_addr", rd_addr, 0);
                chk("rst_en", rd_en, 0);
                chk("rst_scan", scanline, 0);
            end else if (synced) begin
                lit();
            end
        end
    end

    int full_q[$];

    function automatic bit is_full(input int y);
        foreach (full_q[i]) if (full_q[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input int x, input int y);
        @(negedge clk);
        cx = 11'(x);
        cy = 10'(y);
    endtask

    // Lines of no interest are cut to two pixels to keep frames short.
    task automatic line(input int y, input bit full);
        for (int x = 0; x < (full ? 720 : 2); x++) step(x, y);
    endtask

    task automatic frame(input logic r, input int tog);
        rotate = r;
        for (int y = 0; y < 480; y++) begin
            if (y == tog) rotate = ~rotate;
            line(y, is_full(y));
        end
    endtask

    initial begin
        @(negedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        full_q = '{23, 24, 25, 26, 27, 28, 455, 456};
        frame(1'b0, -1);
        rotate = 1'b1;
        for (int y = 0; y < 50; y++) line(y, 1'b0);
        for (int x = 0; x <= 100; x++) step(x, 50);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        full_q = '{200};
        for (int y = 51; y < 480; y++) line(y, is_full(y));
        full_q = '{15, 16, 17, 18, 19, 200, 463, 464};
        frame(1'b1, 200);
        full_q = '{24, 27, 455, 456};
        frame(1'b0, -1);
        @(negedge clk);
        @(negedge clk);
        #1 chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
